mass_and_barrier: RTL and testbench
===================================

MASS_AND_BARRIER -- requirements
Module: mass_and_barrier

Interface
REQ-001 SHALL have parameter N_IN, default 4: number of completion inputs, range 2..32.
REQ-002 SHALL have parameter STICKY, default 1: 1 latches input strobes until the round completes; 0 requires all inputs high together.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024: abort limit for a round, used only when timeout is compiled in.
REQ-004 SHALL use one clock; reset is synchronous and active-high. Port list follows in REQ-005..REQ-013.
REQ-005 SHALL have port CLOCK, input, 1: clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high.
REQ-007 SHALL have port in, input, N_IN: per-source done strobes or levels.
REQ-008 SHALL have port mask, input, N_IN: 1 = source participates in the round.
REQ-009 SHALL have port clear, input, 1: synchronous abort of the current round.
REQ-010 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port pending, output, N_IN: latched arrivals, masked; always 0 when STICKY=0.
REQ-012 SHALL have port arrived_cnt, output, clog2(N_IN+1): popcount of pending.
REQ-013 SHALL have port busy, output, 1: high in COLLECT; timeout, output, 1: one-cycle abort pulse.

Function
REQ-014 SHALL implement states IDLE, COLLECT, FIRE and REARM.
REQ-015 SHALL compute complete = (mask != 0) and (((pending | in) & mask) == mask) when STICKY=1, else (mask != 0) and ((in & mask) == mask).
REQ-016 SHALL, from IDLE or COLLECT with complete=1, go to FIRE next cycle; done=1 for exactly that cycle (latency 1).
REQ-017 SHALL, in IDLE with complete=0 and any (in & mask) bit set and STICKY=1, latch those bits and go to COLLECT.
REQ-018 SHALL, in COLLECT, OR (in & mask) into pending every cycle.
REQ-019 SHALL clear pending on entry to FIRE; strobes arriving during FIRE are latched into the next round.
REQ-020 SHALL leave FIRE for IDLE when STICKY=1; when STICKY=0, leave FIRE for REARM, hold in REARM while complete=1, and return to IDLE when complete=0.
REQ-021 SHALL never fire when mask is all zero; in that case pending stays 0.
REQ-022 SHALL evaluate mask live; deasserting the mask bit of a missing source may complete the round on that cycle.
REQ-023 SHALL give clear priority over completion and arrival: next cycle pending=0, state=IDLE, done=0.
REQ-024 SHALL drive arrived_cnt combinationally from the registered pending.

Reset
REQ-025 SHALL, on reset=1 at a rising edge, set state=IDLE, pending=0, done=0, busy=0, timeout=0, arrived_cnt=0, and the timeout counter to 0.
REQ-026 SHALL give reset priority over clear and inputs; an in-flight round is discarded with no done pulse.

Configuration
REQ-027 SHALL, with MASS_AND_TIMEOUT_EN defined, count cycles spent in COLLECT; at count TIMEOUT_CYCLES-1 with complete=0, pulse timeout for 1 cycle, clear pending and return to IDLE.
REQ-028 SHALL give completion priority over timeout in the same cycle: done pulses and timeout stays 0.
REQ-029 SHALL, without MASS_AND_TIMEOUT_EN, keep the timeout port and tie it to 0, and build no counter logic.

Structure
REQ-030 SHALL place the state enum and the default constants (N_IN, TIMEOUT_CYCLES) in shared package mass_and_pkg.
REQ-031 SHALL implement the N_IN-bit population count as sub-module popcount_n.

Verification
REQ-032 SHALL cover: N_IN=4, STICKY=1, mask=1111, strobes on in[0], in[2], in[1], in[3] on separate cycles -> arrived_cnt steps 1,2,3 -> done=1 exactly one cycle after the in[3] strobe, then pending=0.
REQ-033 SHALL cover: STICKY=0, in=1111 held 10 cycles -> single done pulse; in drops to 0111 then returns to 1111 -> second done pulse.
REQ-034 SHALL cover: mask=1011, pending=0011, mask becomes 0011 -> done next cycle; mask=0000 with in=1111 -> no done.
REQ-035 SHALL cover: pending=0111, clear and in[3] asserted in the same cycle -> no done, pending=0, state IDLE.
REQ-036 SHALL cover: MASS_AND_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, one arrival then silence -> timeout pulse 8 cycles after entering COLLECT, pending=0; completion on the limit cycle -> done=1, timeout=0.
REQ-037 SHALL cover: reset asserted mid-round with pending=0101 -> all outputs 0 next cycle and no done pulse.

Source files
------------

// File: rtl/mass_and_pkg.sv
// Shared types and default sizing for the mass_and barrier.
package mass_and_pkg;

   localparam int unsigned N_IN_DEFAULT           = 4;
   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1024;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      FIRE,
      REARM
   } state_e;

endpackage

// File: rtl/popcount_n.sv
// Population count of an N-bit vector.
module popcount_n #(
   parameter int unsigned N = 4,
   parameter int unsigned W = $clog2(N + 1)
) (
   input  logic [N-1:0] bits_i,
   output logic [W-1:0] count_o
);

   always_comb begin
      count_o = '0;
      for (int unsigned i = 0; i < N; i++) begin
         count_o = count_o + W'(bits_i[i]);
      end
   end

endmodule

// File: rtl/mass_and_barrier.sv
// Completion barrier over N_IN sources with live masking and sticky or level mode.
// Define MASS_AND_TIMEOUT_EN to build the COLLECT-phase abort counter.
module mass_and_barrier
   import mass_and_pkg::*;
#(
   parameter int unsigned N_IN           = N_IN_DEFAULT,
   parameter int unsigned STICKY         = 1,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic                       CLOCK,
   input  logic                       reset,
   input  logic [N_IN-1:0]            in,
   input  logic [N_IN-1:0]            mask,
   input  logic                       clear,
   output logic                       done,
   output logic [N_IN-1:0]            pending,
   output logic [$clog2(N_IN+1)-1:0]  arrived_cnt,
   output logic                       busy,
   output logic                       timeout
);

   if (N_IN < 2 || N_IN > 32 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
      $error("mass_and_barrier: parameter out of range");
   end

   state_e            state_q, state_d;
   logic [N_IN-1:0]   pending_q, pending_d;
   logic [N_IN-1:0]   arrive;
   logic [N_IN-1:0]   seen;
   logic              complete;

`ifdef MASS_AND_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] CNT_LIMIT = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0]     cnt_q, cnt_d;
   logic              timeout_q, timeout_d;
`endif

   assign arrive   = in & mask;
   assign seen     = (STICKY != 0) ? (pending_q | in) : in;
   assign complete = (mask != '0) && ((seen & mask) == mask);

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
`ifdef MASS_AND_TIMEOUT_EN
      timeout_d = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (complete) begin
               state_d   = FIRE;
               pending_d = '0;
            end else if (STICKY != 0 && (pending_q | arrive) != '0) begin
               // Arrivals carried over from a FIRE cycle also open the next round.
               state_d   = COLLECT;
               pending_d = pending_q | arrive;
            end
         end
         COLLECT: begin
            if (complete) begin
               state_d   = FIRE;
               pending_d = '0;
            end
`ifdef MASS_AND_TIMEOUT_EN
            else if (cnt_q == CNT_LIMIT) begin
               state_d   = IDLE;
               pending_d = '0;
               timeout_d = 1'b1;
            end
`endif
            else begin
               pending_d = pending_q | arrive;
            end
         end
         FIRE: begin
            state_d   = (STICKY != 0) ? IDLE : REARM;
            pending_d = (STICKY != 0) ? arrive : '0;
         end
         REARM: begin
            if (!complete) state_d = IDLE;
         end
         default: begin
            state_d   = IDLE;
            pending_d = '0;
         end
      endcase
      if (clear) begin
         state_d   = IDLE;
         pending_d = '0;
`ifdef MASS_AND_TIMEOUT_EN
         timeout_d = 1'b0;
`endif
      end
   end

`ifdef MASS_AND_TIMEOUT_EN
   assign cnt_d = (state_q == COLLECT && state_d == COLLECT) ? cnt_q + 1'b1 : '0;
`endif

   always_ff @(posedge CLOCK) begin
      if (reset) begin
         state_q   <= IDLE;
         pending_q <= '0;
`ifdef MASS_AND_TIMEOUT_EN
         cnt_q     <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
`ifdef MASS_AND_TIMEOUT_EN
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   assign done    = (state_q == FIRE);
   assign busy    = (state_q == COLLECT);
   assign pending = pending_q;
`ifdef MASS_AND_TIMEOUT_EN
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   popcount_n #(
      .N (N_IN),
      .W ($clog2(N_IN + 1))
   ) u_popcount (
      .bits_i  (pending_q),
      .count_o (arrived_cnt)
   );

endmodule

// File: tb/tb_mass_and_barrier.sv
// Checks a sticky and a level-mode barrier against a round-level reference model.
module tb_mass_and_barrier;

   localparam int unsigned TO_LIM = 8;
`ifdef MASS_AND_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clr = 1'b0;
   logic [3:0] din = '0;
   logic [3:0] dmask = '0;

   logic       s_done, s_busy, s_to;
   logic [3:0] s_pend;
   logic [2:0] s_cnt;
   logic       l_done, l_busy, l_to;
   logic [3:0] l_pend;
   logic [2:0] l_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   // sticky model: arrivals so far, whether a round is open, cycles it has been open
   logic [3:0] m_pend = '0;
   logic       m_done = 1'b0, m_busy = 1'b0, m_to = 1'b0;
   int         m_age = -1;
   // level model: fired and still waiting for the all-high condition to drop
   logic       l_exp_done = 1'b0, l_blk = 1'b0;

   always #5 clk = ~clk;

   mass_and_barrier #(.N_IN(4), .STICKY(1), .TIMEOUT_CYCLES(TO_LIM)) dut_s (
      .CLOCK(clk), .reset(rst), .in(din), .mask(dmask), .clear(clr),
      .done(s_done), .pending(s_pend), .arrived_cnt(s_cnt), .busy(s_busy), .timeout(s_to)
   );

   mass_and_barrier #(.N_IN(4), .STICKY(0), .TIMEOUT_CYCLES(TO_LIM)) dut_l (
      .CLOCK(clk), .reset(rst), .in(din), .mask(dmask), .clear(clr),
      .done(l_done), .pending(l_pend), .arrived_cnt(l_cnt), .busy(l_busy), .timeout(l_to)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic [3:0] i, input logic [3:0] m, input logic c, input logic r);
      logic all_s, all_l;
      all_s = (m != 0) && (((m_pend | i) & m) == m);
      all_l = (m != 0) && ((i & m) == m);
      if (r || c) begin
         m_pend = '0; m_done = 0; m_busy = 0; m_to = 0; m_age = -1;
      end else if (m_done) begin
         m_pend = i & m; m_done = 0; m_busy = 0; m_to = 0; m_age = -1;
      end else if (all_s) begin
         m_pend = '0; m_done = 1; m_busy = 0; m_to = 0; m_age = -1;
      end else if (TO_EN && m_busy && m_age == int'(TO_LIM) - 1) begin
         m_pend = '0; m_to = 1; m_busy = 0; m_age = -1;
      end else begin
         m_to = 0;
         m_pend = m_pend | (i & m);
         if (m_busy) m_age++;
         else if (m_pend != 0) begin m_busy = 1; m_age = 0; end
      end
      if (r || c) begin
         l_exp_done = 0; l_blk = 0;
      end else if (l_exp_done) begin
         l_exp_done = 0; l_blk = 1;
      end else if (l_blk) begin
         if (!all_l) l_blk = 0;
      end else begin
         l_exp_done = all_l;
      end
   endtask

   task automatic step(input logic [3:0] i, input logic [3:0] m,
                       input logic c = 1'b0, input logic r = 1'b0);
      @(negedge clk);
      din = i; dmask = m; clr = c; rst = r;
      model(i, m, c, r);
      @(posedge clk);
      #1;
      chk("s_done",    32'(s_done), 32'(m_done));
      chk("s_pending", 32'(s_pend), 32'(m_pend));
      chk("s_cnt",     32'(s_cnt),  32'($countones(m_pend)));
      chk("s_busy",    32'(s_busy), 32'(m_busy));
      chk("s_timeout", 32'(s_to),   32'(m_to));
      chk("l_done",    32'(l_done), 32'(l_exp_done));
      chk("l_pending", 32'(l_pend), 32'(0));
      chk("l_cnt",     32'(l_cnt),  32'(0));
      chk("l_busy",    32'(l_busy), 32'(0));
      chk("l_timeout", 32'(l_to),   32'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      logic [3:0] ri, rm;

      step(4'h0, 4'h0, 1'b0, 1'b1);
      chk("reset_done", 32'(s_done), 32'(0));
      chk("reset_cnt",  32'(s_cnt),  32'(0));

      // strobes on separate cycles, done one cycle after the last
      step(4'h1, 4'hF); chk("seq_cnt1", 32'(s_cnt), 32'(1));
      step(4'h4, 4'hF); chk("seq_cnt2", 32'(s_cnt), 32'(2));
      step(4'h2, 4'hF); chk("seq_cnt3", 32'(s_cnt), 32'(3));
      chk("seq_nodone", 32'(s_done), 32'(0));
      step(4'h8, 4'hF); chk("seq_done", 32'(s_done), 32'(1));
      chk("seq_pend0", 32'(s_pend), 32'(0));
      step(4'h0, 4'hF); chk("seq_done_once", 32'(s_done), 32'(0));

      // level mode: held all-high fires once, a drop rearms it
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         step(4'hF, 4'hF);
         if (l_done) pulses++;
      end
      chk("lvl_single_pulse", 32'(pulses), 32'(1));
      step(4'h7, 4'hF); chk("lvl_drop", 32'(l_done), 32'(0));
      step(4'hF, 4'hF); chk("lvl_second", 32'(l_done), 32'(1));
      step(4'h0, 4'hF, 1'b1);

      // live mask completes a round; empty mask never fires
      step(4'h1, 4'hB);
      step(4'h2, 4'hB); chk("mask_pend3", 32'(s_pend), 32'(3));
      step(4'h0, 4'h3); chk("mask_done", 32'(s_done), 32'(1));
      step(4'h0, 4'h3);
      for (int k = 0; k < 3; k++) begin
         step(4'hF, 4'h0);
         chk("mask0_done", 32'(s_done), 32'(0));
         chk("mask0_pend", 32'(s_pend), 32'(0));
      end

      // clear beats a completing strobe
      step(4'h1, 4'hF); step(4'h2, 4'hF); step(4'h4, 4'hF);
      chk("clr_pend7", 32'(s_pend), 32'(7));
      step(4'h8, 4'hF, 1'b1);
      chk("clr_done", 32'(s_done), 32'(0));
      chk("clr_pend", 32'(s_pend), 32'(0));
      chk("clr_busy", 32'(s_busy), 32'(0));
      step(4'h0, 4'hF); chk("clr_after", 32'(s_done), 32'(0));

`ifdef MASS_AND_TIMEOUT_EN
      step(4'h1, 4'hF);
      for (int k = 0; k < 7; k++) begin
         step(4'h0, 4'hF);
         chk("to_early", 32'(s_to), 32'(0));
      end
      step(4'h0, 4'hF);
      chk("to_pulse", 32'(s_to), 32'(1));
      chk("to_pend",  32'(s_pend), 32'(0));
      step(4'h0, 4'hF); chk("to_once", 32'(s_to), 32'(0));
      step(4'h1, 4'hF);
      for (int k = 0; k < 7; k++) step(4'h0, 4'hF);
      step(4'hE, 4'hF);
      chk("to_lim_done", 32'(s_done), 32'(1));
      chk("to_lim_to",   32'(s_to),   32'(0));
      step(4'h0, 4'hF);
`endif

      // reset mid-round discards it
      step(4'h1, 4'hF); step(4'h4, 4'hF);
      chk("rst_pend5", 32'(s_pend), 32'(5));
      step(4'hF, 4'hF, 1'b0, 1'b1);
      chk("rst_done", 32'(s_done), 32'(0));
      chk("rst_pend", 32'(s_pend), 32'(0));
      chk("rst_busy", 32'(s_busy), 32'(0));
      chk("rst_to",   32'(s_to),   32'(0));
      step(4'h0, 4'hF); chk("rst_after", 32'(s_done), 32'(0));

      for (int k = 0; k < 600; k++) begin
         rm = ($urandom_range(9) < 7) ? 4'hF : 4'($urandom);
         ri = ($urandom_range(3) == 0) ? 4'hF : (4'($urandom) & 4'($urandom) & 4'($urandom));
         step(ri, rm, ($urandom_range(49) == 0), ($urandom_range(99) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
